// File: rtl/surf_command_sender_v3_pkg.sv
// Shared definitions for the SURF command sender: FSM state encoding,
// frame-length helper and the idle level of a command line.
package surf_command_sender_v3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } sender_state_t;

   // Level a CMD line rests at between frames and during the gap bit.
   localparam logic IDLE_LEVEL = 1'b0;

   // Bits on the line per frame: start + buffer + event ID + parity.
   function automatic int frame_len(input int id_width, input int buf_width);
      return buf_width + id_width + 2;
   endfunction

endpackage

// File: rtl/surf_command_sender_v3_if.sv
// Push-side bundle between trigger/readout control (master) and the
// command sender (slave), plus FSM/queue observability from the sender.
//
// Handshake: start_i is the valid, !full_o is the ready. An entry
// {mask_i, buffer_i, event_id_i} is transferred on a rising clock edge where
// start_i && !full_o. start_i while full_o is discarded and answered by a
// one-cycle drop_o pulse on the following cycle. Payload only needs to be
// stable on the cycle start_i is high.
interface surf_command_sender_v3_if #(
   parameter int NUM_SURFS   = 12,
   parameter int ID_WIDTH    = 32,
   parameter int BUF_WIDTH   = 2,
   parameter int QDEPTH_LOG2 = 2
) ();
   import surf_command_sender_v3_pkg::*;

   logic [ID_WIDTH-1:0]  event_id_i;
   logic [BUF_WIDTH-1:0] buffer_i;
   logic [NUM_SURFS-1:0] mask_i;
   logic                 start_i;
   logic                 full_o;
   logic                 drop_o;

   // Observability: current FSM state and queue occupancy.
   sender_state_t        state_dbg;
   logic [QDEPTH_LOG2:0] count_dbg;

   modport master (
      output event_id_i, buffer_i, mask_i, start_i,
      input  full_o, drop_o, state_dbg, count_dbg
   );

   modport slave (
      input  event_id_i, buffer_i, mask_i, start_i,
      output full_o, drop_o, state_dbg, count_dbg
   );

endinterface

// File: rtl/surf_command_sender_v3_queue.sv
// Synchronous show-ahead FIFO holding pending command entries.
// The head entry is visible on rd_data_o whenever empty_o is low; pop_i
// consumes it on the next edge. Push and pop may coincide.
module surf_command_sender_v3_queue #(
   parameter int WIDTH      = 46,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   output logic [WIDTH-1:0]      rd_data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   count_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q;
   logic                  do_push;
   logic                  do_pop;

   assign full_o    = (count_q == DEPTH_CNT);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem[rd_ptr_q];
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/surf_command_sender_v3.sv
// Serial command broadcaster to the SURF boards. Entries are queued, then
// sent one at a time as start bit, buffer (LSB first), event ID (LSB first)
// and an even-parity bit, one bit per prescaler period, with one idle bit
// between frames. CMD_o is the per-SURF masked copy, registered for the IOB.
module surf_command_sender_v3
   import surf_command_sender_v3_pkg::*;
#(
   parameter int NUM_SURFS   = 12,
   parameter int ID_WIDTH    = 32,
   parameter int BUF_WIDTH   = 2,
   parameter int DIV_LOG2    = 2,
   parameter int QDEPTH_LOG2 = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   surf_command_sender_v3_if.slave cmd_if,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [NUM_SURFS-1:0] CMD_o,
   output logic                 CMD_debug_o
);

   localparam int F       = frame_len(ID_WIDTH, BUF_WIDTH);
   localparam int CNT_W   = $clog2(F);
   localparam int P       = 1 << DIV_LOG2;
   localparam int PRESC_W = DIV_LOG2 + 1;
   localparam int QW      = NUM_SURFS + BUF_WIDTH + ID_WIDTH;

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(P - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(F - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

   // Queue
   logic                 q_push;
   logic                 q_pop;
   logic [QW-1:0]        q_wr;
   logic [QW-1:0]        q_rd;
   logic                 q_full;
   logic                 q_empty;
   logic [QDEPTH_LOG2:0] q_count;

   // Head entry fields and the frame it expands to.
   logic [NUM_SURFS-1:0] head_mask;
   logic [BUF_WIDTH-1:0] head_buf;
   logic [ID_WIDTH-1:0]  head_id;
   logic [F-1:0]         head_frame;

   // Prescaler
   logic [PRESC_W-1:0]   presc_q;
   logic                 tick;

   // FSM and datapath
   sender_state_t        state_q;
   logic [F-2:0]         shreg_q;     // bits still to send after the current one
   logic [CNT_W-1:0]     bit_cnt_q;
   logic [NUM_SURFS-1:0] mask_q;
   logic                 cmd_q;       // current line level
   logic                 busy_q;
   logic                 done_q;
   logic                 drop_q;

   assign q_wr   = {cmd_if.mask_i, cmd_if.buffer_i, cmd_if.event_id_i};
   assign q_push = cmd_if.start_i && !q_full;
   // A frame may start only from IDLE or at the end of the gap bit.
   assign q_pop  = tick && !q_empty && ((state_q == ST_IDLE) || (state_q == ST_GAP));

   assign head_mask  = q_rd[QW-1 -: NUM_SURFS];
   assign head_buf   = q_rd[ID_WIDTH +: BUF_WIDTH];
   assign head_id    = q_rd[ID_WIDTH-1:0];
   assign head_frame = {^{head_buf, head_id}, head_id, head_buf, 1'b1};

   surf_command_sender_v3_queue #(
      .WIDTH      (QW),
      .DEPTH_LOG2 (QDEPTH_LOG2)
   ) u_queue (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (q_push),
      .pop_i     (q_pop),
      .wr_data_i (q_wr),
      .rd_data_o (q_rd),
      .full_o    (q_full),
      .empty_o   (q_empty),
      .count_o   (q_count)
   );

   assign tick = (presc_q == PRESC_MAX);

   // Free-running bit-period prescaler; tick is high on the last clock of each period.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PRESC_ONE;
      end
   end

   // Frame sequencer: pops on a tick, shifts one bit per tick, then one gap bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         mask_q    <= '0;
         cmd_q     <= IDLE_LEVEL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_GAP: begin
               if (tick) begin
                  if (!q_empty) begin
                     state_q   <= ST_SEND;
                     shreg_q   <= head_frame[F-1:1];
                     cmd_q     <= head_frame[0];
                     mask_q    <= head_mask;
                     bit_cnt_q <= '0;
                     busy_q    <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_SEND: begin
               if (tick) begin
                  if (bit_cnt_q == CNT_LAST) begin
                     state_q <= ST_GAP;
                     cmd_q   <= IDLE_LEVEL;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_ONE;
                     cmd_q     <= shreg_q[0];
                     shreg_q   <= {IDLE_LEVEL, shreg_q[F-2:1]};
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cmd_q   <= IDLE_LEVEL;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // IOB output stage: one flop per SURF line, gated by the latched mask.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         CMD_o <= '0;
      end else begin
         CMD_o <= {NUM_SURFS{cmd_q}} & mask_q;
      end
   end

   // Drop indication: a push presented while the queue was full.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= cmd_if.start_i && q_full;
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign CMD_debug_o      = cmd_q;
   assign cmd_if.full_o    = q_full;
   assign cmd_if.drop_o    = drop_q;
   assign cmd_if.state_dbg = state_q;
   assign cmd_if.count_dbg = q_count;

endmodule
